odu_cfg_host: RTL and testbench

ODU_CFG_HOST -- requirements
Module: odu_cfg_host

---
 rtl/odu_cfg_host.sv | 141 ++++++++++++++
 tb/tb_odu_cfg_host.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/odu_cfg_host.sv
// ODU configuration bus master: one chip-select framed register
// access per command, with programmable setup/strobe/hold phases.
module odu_cfg_host #(
  parameter int DATA_WIDTH_CFG = 16,
  parameter int ADDR_WIDTH_CFG = 5,
  parameter int SETUP_CYC      = 1,
  parameter int STROBE_CYC     = 2,
  parameter int HOLD_CYC       = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [ADDR_WIDTH_CFG-1:0] cmd_addr,
  input  logic [DATA_WIDTH_CFG-1:0] cmd_wdata,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH_CFG-1:0] rsp_rdata,
  output logic                      busy,
  output logic                      cfg_n_cs,
  output logic                      cfg_n_we,
  output logic                      cfg_n_oe,
  output logic [ADDR_WIDTH_CFG-1:0] cfg_addr,
  output logic [DATA_WIDTH_CFG-1:0] cfg_din,
  input  logic [DATA_WIDTH_CFG-1:0] cfg_dout
);

  localparam int MAX_SP = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_C  = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] S_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] P_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] H_LD = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      we_q, we_d;
  logic [ADDR_WIDTH_CFG-1:0] addr_q, addr_d;
  logic [DATA_WIDTH_CFG-1:0] din_q, din_d;
  logic [DATA_WIDTH_CFG-1:0] rdata_q, rdata_d;
  logic                      rsp_q, rsp_d;
  logic                      n_cs_q, n_cs_d;
  logic                      n_we_q, n_we_d;
  logic                      n_oe_q, n_oe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    rsp_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = SETUP;
          cnt_d   = S_LD;
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          din_d   = cmd_wdata;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = P_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = H_LD;
          if (!we_q) rdata_d = cfg_dout;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          rsp_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Strobes are decoded from the next state so the pins come straight from flops
    n_cs_d = (state_d == IDLE);
    n_we_d = !((state_d == STROBE) && we_d);
    n_oe_d = !((state_d == STROBE) && !we_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      rsp_q   <= 1'b0;
      n_cs_q  <= 1'b1;
      n_we_q  <= 1'b1;
      n_oe_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      rsp_q   <= rsp_d;
      n_cs_q  <= n_cs_d;
      n_we_q  <= n_we_d;
      n_oe_q  <= n_oe_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;
  assign cfg_n_cs  = n_cs_q;
  assign cfg_n_we  = n_we_q;
  assign cfg_n_oe  = n_oe_q;
  assign cfg_addr  = addr_q;
  assign cfg_din   = din_q;

endmodule

// File: tb/tb_odu_cfg_host.sv
// Bench for odu_cfg_host: cycle model of the pin timing plus a
// response scoreboard keyed by expected completion cycle.
module tb_odu_cfg_host;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [4:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic        cfg_n_cs;
  logic        cfg_n_we;
  logic        cfg_n_oe;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_din;
  logic [15:0] cfg_dout;

  odu_cfg_host dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .cfg_n_cs  (cfg_n_cs),
    .cfg_n_we  (cfg_n_we),
    .cfg_n_oe  (cfg_n_oe),
    .cfg_addr  (cfg_addr),
    .cfg_din   (cfg_din),
    .cfg_dout  (cfg_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [32];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          cur_acc = -100;
  logic        cur_we = 1'b0;
  logic [4:0]  cur_addr = '0;
  logic [15:0] cur_data = '0;
  logic [15:0] last_rd = '0;
  bit          started = 1'b0;
  int          ofs;
  bit          act;
  exp_t        e;

  assign cfg_dout = mem[cfg_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h exp %h", tag, cyc, got, exp);
    end
  endtask

  task automatic send(input logic we, input logic [4:0] a,
                      input logic [15:0] d);
    int   n;
    logic rdy;
    n = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    do begin
      @(negedge clk);
      rdy = cmd_ready;
      n++;
    end while (!rdy && n < 20);
    if (!rdy) begin
      chk("accept_timeout", 0, 1);
    end else begin
      cur_acc  = cyc;
      cur_we   = we;
      cur_addr = a;
      cur_data = d;
      if (!we) last_rd = mem[a];
      sb.push_back('{cyc + 5, last_rd});
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Per-cycle pin model, sampled 2 time units after the falling edge
  always @(negedge clk) begin
    #2;
    if (started && !rst) begin
      ofs = cyc - cur_acc;
      act = (ofs >= 1 && ofs <= 4);
      chk("n_cs", cfg_n_cs, !act);
      chk("ready", cmd_ready, !act);
      chk("busy", busy, act);
      chk("n_we", cfg_n_we, !(ofs >= 2 && ofs <= 3 && cur_we));
      chk("n_oe", cfg_n_oe, !(ofs >= 2 && ofs <= 3 && !cur_we));
      if (act) begin
        chk("addr", cfg_addr, cur_addr);
        chk("din", cfg_din, cur_data);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_spurious", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_cyc", cyc, e.cyc);
          chk("rsp_rdata", rsp_rdata, e.rdata);
        end
      end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
        chk("rsp_missing", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  int t1;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
    mem[5'h0B] = 16'hBEEF;
    mem[5'h05] = 16'h1234;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    #2;
    chk("rst_n_cs", cfg_n_cs, 1);
    chk("rst_n_we", cfg_n_we, 1);
    chk("rst_n_oe", cfg_n_oe, 1);
    chk("rst_addr", cfg_addr, 0);
    chk("rst_din", cfg_din, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;

    send(1'b1, 5'h00, 16'h0001);
    wait_done();
    chk("wr_keeps_rdata", rsp_rdata, 0);

    send(1'b0, 5'h0B, 16'h0000);
    wait_done();
    chk("rd_rdata", rsp_rdata, 16'hBEEF);

    send(1'b1, 5'h02, 16'hAAAA);
    t1 = cur_acc;
    send(1'b1, 5'h03, 16'h5555);
    chk("b2b_accept", cur_acc - t1, 5);
    wait_done();

    send(1'b1, 5'h04, 16'h1111);
    t1 = cur_acc;
    @(posedge clk);
    #1;
    send(1'b1, 5'h1F, 16'h2222);
    chk("busy_ignored", cur_acc - t1, 5);
    wait_done();

    // Abort a read in its strobe phase
    send(1'b0, 5'h0B, 16'h0000);
    repeat (3) @(negedge clk);
    #3;
    rst = 1'b1;
    started = 1'b0;
    #1;
    chk("abort_n_cs", cfg_n_cs, 1);
    chk("abort_n_oe", cfg_n_oe, 1);
    chk("abort_busy", busy, 0);
    chk("abort_rsp", rsp_valid, 0);
    chk("abort_rdata", rsp_rdata, 0);
    sb.delete();
    cur_acc = -100;
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    t1 = cyc;
    send(1'b1, 5'h03, 16'h7777);
    chk("post_rst_accept", cur_acc - t1, 0);
    send(1'b0, 5'h05, 16'h0000);
    wait_done();
    chk("wr_rd_rdata", rsp_rdata, 16'h1234);

    for (int i = 0; i < 8; i++) begin
      send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           16'($urandom));
    end
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
